// File: rtl/fum_hazard_unit.sv
// fum_hazard_unit
//   Hazard, forwarding and flush controller for the FUM pipelined core.
//   A shadow pipeline tracks the destination register of every in-flight
//   instruction after ID (entry 0 = EX ... entry DEPTH-1 = WB). From it the
//   unit derives the load-use stall and the registered EX operand forwarding
//   selects. It also produces the IF/ID flush on a taken branch, and keeps
//   saturating stall/flush cycle counters.
//
//   Build option: define FUM_R0_HARDWIRED_EN to treat r0 as a constant zero
//   register. A destination of r0 then never matches, so r0 never forwards
//   and never stalls. Left undefined, r0 is hazard-tracked like any other
//   register.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   id_valid          ID holds a real instruction
//   id_rs/id_rt       source register addresses
//   id_rs_used/_rt_   the corresponding source is actually read
//   id_dst, id_wen    destination address / register write enable
//   id_is_load        instruction is a load
//   br_taken          branch resolved taken in EX this cycle
//   ext_stall         memory busy: freeze everything
//   stall             hold PC and IF/ID, insert a bubble into EX
//   flush             kill the IF/ID contents
//   fwd_a, fwd_b      EX operand source: 0 = register file, k = entry k
//   stall_cnt         saturating count of cycles with stall = 1
//   flush_cnt         saturating count of cycles with flush = 1

module fum_hazard_unit #(
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_RDY   = 2,
    parameter int unsigned FWD_W      = $clog2(DEPTH),
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_wen,
    input  logic                  id_is_load,
    input  logic                  br_taken,
    input  logic                  ext_stall,
    output logic                  stall,
    output logic                  flush,
    output logic [FWD_W-1:0]      fwd_a,
    output logic [FWD_W-1:0]      fwd_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
        logic                  wen;
        logic                  is_load;
    } entry_t;

    entry_t           sh [DEPTH];
    entry_t           id_entry;
    logic             hz;
    logic             bubble;
    logic [FWD_W-1:0] fwd_a_nxt;
    logic [FWD_W-1:0] fwd_b_nxt;

    function automatic logic match(input entry_t e,
                                   input logic [REG_ADDR_W-1:0] src,
                                   input logic used);
        logic m;
        m = used && e.valid && e.wen && (e.dst == src);
`ifdef FUM_R0_HARDWIRED_EN
        m = m && (e.dst != '0);
`endif
        return m;
    endfunction

    // A load in entry j reaches entry j+1 by the time the consumer is in EX;
    // if that is still short of LOAD_RDY the data cannot be forwarded yet.
    always_comb begin
        hz = 1'b0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (sh[j].is_load && (j + 1 < LOAD_RDY) &&
                (match(sh[j], id_rs, id_rs_used) || match(sh[j], id_rt, id_rt_used)))
                hz = 1'b1;
        end
    end

    assign flush  = br_taken & ~ext_stall;
    assign stall  = hz & id_valid & ~flush & ~ext_stall;
    assign bubble = flush | stall | ~id_valid;

    // Select is computed while the consumer is in ID, so a producer now in
    // entry k-1 sits in entry k when the select is used in EX. Only entries
    // 0..DEPTH-2 are scanned: a producer already in WB has written the
    // register file before ID read it. Scanning from the oldest down lets the
    // youngest producer overwrite and win.
    always_comb begin
        fwd_a_nxt = '0;
        fwd_b_nxt = '0;
        for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
            if (match(sh[k-1], id_rs, id_rs_used))
                fwd_a_nxt = FWD_W'(k);
            if (match(sh[k-1], id_rt, id_rt_used))
                fwd_b_nxt = FWD_W'(k);
        end
    end

    always_comb begin
        id_entry.valid   = id_valid;
        id_entry.dst     = id_dst;
        id_entry.wen     = id_wen;
        id_entry.is_load = id_is_load;
`ifdef FUM_R0_HARDWIRED_EN
        if (id_dst == '0)
            id_entry.wen = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned j = 0; j < DEPTH; j++)
                sh[j] <= '0;
            fwd_a     <= '0;
            fwd_b     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!ext_stall) begin
            for (int unsigned j = 1; j < DEPTH; j++)
                sh[j] <= sh[j-1];
            sh[0] <= bubble ? '0 : id_entry;
            fwd_a <= bubble ? '0 : fwd_a_nxt;
            fwd_b <= bubble ? '0 : fwd_b_nxt;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fum_hazard_unit.sv
// tb_fum_hazard_unit
//   Self-checking bench for fum_hazard_unit (DEPTH=3, LOAD_RDY=2, CNT_W=4).
//   Each step drives one ID instruction, pushes the expected stall/flush and
//   the expected registered forwarding selects onto a queue, then pops and
//   compares them once the DUT has produced them.

module tb_fum_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [2:0] id_rs;
    logic [2:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic [2:0] id_dst;
    logic       id_wen;
    logic       id_is_load;
    logic       br_taken;
    logic       ext_stall;
    logic       stall;
    logic       flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;

    fum_hazard_unit #(
        .REG_ADDR_W(3),
        .DEPTH     (3),
        .LOAD_RDY  (2),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_rs_used(id_rs_used),
        .id_rt_used(id_rt_used),
        .id_dst    (id_dst),
        .id_wen    (id_wen),
        .id_is_load(id_is_load),
        .br_taken  (br_taken),
        .ext_stall (ext_stall),
        .stall     (stall),
        .flush     (flush),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       s;
        logic       f;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned exp_sc = 0;
    int unsigned exp_fc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                         input logic ru, input logic tu, input logic [2:0] dst,
                         input logic w, input logic ld, input logic br, input logic xs);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_rs_used = ru;
        id_rt_used = tu;
        id_dst     = dst;
        id_wen     = w;
        id_is_load = ld;
        br_taken   = br;
        ext_stall  = xs;
    endtask

    // One clock: drive, push expectation, sample comb outputs mid-cycle,
    // pop and compare after the edge.
    task automatic step(input string tag, input logic v, input logic [2:0] rs,
                        input logic [2:0] rt, input logic ru, input logic tu,
                        input logic [2:0] dst, input logic w, input logic ld,
                        input logic br, input logic xs, input logic es,
                        input logic ef, input logic [1:0] efa, input logic [1:0] efb);
        exp_t e;
        logic obs_s;
        logic obs_f;
        drive(v, rs, rt, ru, tu, dst, w, ld, br, xs);
        exp_q.push_back('{tag, es, ef, efa, efb});
        @(negedge clk);
        obs_s = stall;
        obs_f = flush;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.s && exp_sc != 15) exp_sc++;
        if (e.f && exp_fc != 15) exp_fc++;
        check({e.tag, ".stall"}, 32'(obs_s), 32'(e.s));
        check({e.tag, ".flush"}, 32'(obs_f), 32'(e.f));
        check({e.tag, ".fwd_a"}, 32'(fwd_a), 32'(e.fa));
        check({e.tag, ".fwd_b"}, 32'(fwd_b), 32'(e.fb));
        check({e.tag, ".stall_cnt"}, 32'(stall_cnt), exp_sc);
        check({e.tag, ".flush_cnt"}, 32'(flush_cnt), exp_fc);
    endtask

    task automatic alu(input string tag, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] dst, input logic es,
                       input logic [1:0] efa, input logic [1:0] efb);
        step(tag, 1'b1, rs, rt, 1'b1, 1'b1, dst, 1'b1, 1'b0, 1'b0, 1'b0, es, 1'b0, efa, efb);
    endtask

    task automatic lw(input string tag, input logic [2:0] dst);
        step(tag, 1'b1, 3'd5, 3'd5, 1'b1, 1'b0, dst, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    endtask

    task automatic nop(input string tag);
        step(tag, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst.stall", 32'(stall), 0);
        check("rst.flush", 32'(flush), 0);
        check("rst.fwd_a", 32'(fwd_a), 0);
        check("rst.fwd_b", 32'(fwd_b), 0);
        check("rst.stall_cnt", 32'(stall_cnt), 0);
        check("rst.flush_cnt", 32'(flush_cnt), 0);

        // back-to-back and distance-2 ALU dependencies
        alu("add_r1",     3'd2, 3'd3, 3'd1, 1'b0, 2'd0, 2'd0);
        alu("sub_r2_r1",  3'd1, 3'd3, 3'd2, 1'b0, 2'd1, 2'd0);
        nop("n1");
        alu("add_r1b",    3'd6, 3'd7, 3'd1, 1'b0, 2'd0, 2'd0);
        nop("n2");
        alu("or_rs_d2",   3'd1, 3'd5, 3'd4, 1'b0, 2'd2, 2'd0);
        alu("add_r1c",    3'd6, 3'd7, 3'd1, 1'b0, 2'd0, 2'd0);
        nop("n3");
        alu("or_rt_d2",   3'd5, 3'd1, 3'd4, 1'b0, 2'd0, 2'd2);
        alu("sub_r6_r4",  3'd4, 3'd4, 3'd6, 1'b0, 2'd1, 2'd1);
        alu("add_r6",     3'd7, 3'd7, 3'd6, 1'b0, 2'd0, 2'd0);
        alu("youngest",   3'd6, 3'd6, 3'd3, 1'b0, 2'd1, 2'd1);
        nop("n4");
        nop("n5");
        nop("n6");

        // load-use: one stall, then forward from entry 2
        lw("lu_lw", 3'd2);
        alu("lu_stall",   3'd2, 3'd2, 3'd3, 1'b1, 2'd0, 2'd0);
        alu("lu_fwd",     3'd2, 3'd2, 3'd3, 1'b0, 2'd2, 2'd2);
        nop("n7");
        nop("n8");
        nop("n9");

        // taken branch wins over the hazard and bubbles entry 0
        lw("br_lw", 3'd2);
        step("br_hz", 1'b1, 3'd2, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b1, 2'd0, 2'd0);
        alu("br_bubble",  3'd3, 3'd6, 3'd7, 1'b0, 2'd0, 2'd0);
        nop("n10");
        nop("n11");
        nop("n12");

        // ext_stall freeze for 3 cycles, branch during freeze is ignored
        alu("fz_add_r1",  3'd6, 3'd7, 3'd1, 1'b0, 2'd0, 2'd0);
        alu("fz_sub_r2",  3'd1, 3'd1, 3'd2, 1'b0, 2'd1, 2'd1);
        step("fz_hold0", 1'b1, 3'd2, 3'd1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1,
             1'b0, 1'b0, 2'd1, 2'd1);
        step("fz_hold1", 1'b1, 3'd2, 3'd1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1,
             1'b0, 1'b0, 2'd1, 2'd1);
        step("fz_hold2", 1'b1, 3'd2, 3'd1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1,
             1'b0, 1'b0, 2'd1, 2'd1);
        alu("fz_resume",  3'd2, 3'd1, 3'd4, 1'b0, 2'd1, 2'd2);
        nop("n13");
        nop("n14");
        nop("n15");

        // r0 as a load destination
        lw("r0_lw", 3'd0);
`ifdef FUM_R0_HARDWIRED_EN
        alu("r0_use",     3'd0, 3'd0, 3'd1, 1'b0, 2'd0, 2'd0);
`else
        alu("r0_use",     3'd0, 3'd0, 3'd1, 1'b1, 2'd0, 2'd0);
        alu("r0_fwd",     3'd0, 3'd0, 3'd1, 1'b0, 2'd2, 2'd2);
`endif
        nop("n16");
        nop("n17");
        nop("n18");

        // stall counter saturation at 15 with CNT_W=4
        for (int i = 0; i < 20; i++) begin
            lw("sat_lw", 3'd2);
            alu("sat_use", 3'd2, 3'd2, 3'd3, 1'b1, 2'd0, 2'd0);
        end
        check("sat.stall_cnt", 32'(stall_cnt), 15);

        // reset while a stall is being asserted
        lw("mr_lw", 3'd2);
        drive(1'b1, 3'd2, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mr.stall_pre", 32'(stall), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_sc = 0;
        exp_fc = 0;
        check("mr.fwd_a", 32'(fwd_a), 0);
        check("mr.fwd_b", 32'(fwd_b), 0);
        check("mr.stall_cnt", 32'(stall_cnt), 0);
        check("mr.flush_cnt", 32'(flush_cnt), 0);
        alu("mr_after",   3'd2, 3'd2, 3'd3, 1'b0, 2'd0, 2'd0);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
